// File: rtl/usb_rx_decoder_pkg.sv
// USBPkg: shared encodings for the USB receive path.
// Holds bus-state codes, the SYNC pattern, PID constants, CRC polynomials
// and residuals, and the receive FSM state enum.
package USBPkg;

  // Line states as {DP, DM}
  localparam logic [1:0] BUS_SE0 = 2'b00;
  localparam logic [1:0] BUS_K   = 2'b01;
  localparam logic [1:0] BUS_J   = 2'b10;
  localparam logic [1:0] BUS_SE1 = 2'b11;

  // Eight line states of SYNC, oldest in the top bits: K J K J K J K K
  localparam logic [15:0] SYNC_PATTERN = {BUS_K, BUS_J, BUS_K, BUS_J,
                                          BUS_K, BUS_J, BUS_K, BUS_K};

  // PID type lives in the two LSBs of the PID nibble
  localparam logic [1:0] PID_TYPE_SPECIAL   = 2'b00;
  localparam logic [1:0] PID_TYPE_TOKEN     = 2'b01;
  localparam logic [1:0] PID_TYPE_HANDSHAKE = 2'b10;
  localparam logic [1:0] PID_TYPE_DATA      = 2'b11;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  // Serial CRCs: shift left, feedback from MSB, all-ones init
  localparam logic [4:0]  CRC5_POLY      = 5'b00101;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_RECV,
    ST_EOP1,
    ST_EOP2,
    ST_DONE,
    ST_ERR
  } rx_state_e;

endpackage

// File: rtl/usb_rx_decoder_crc_chk.sv
// usb_rx_crc_chk: serial CRC5/CRC16 residual checker over the kept bits
// that follow the PID. The result is selected by the PID type.
module usb_rx_crc_chk
  import USBPkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       in_bit,
  input  logic [1:0] kind,
  output logic       ok
);

  logic [4:0]  crc5_q, crc5_d;
  logic [15:0] crc16_q, crc16_d;

  // Next CRC values for one incoming bit
  always_comb begin
    crc5_d  = {crc5_q[3:0], 1'b0} ^ ((in_bit ^ crc5_q[4]) ? CRC5_POLY : 5'd0);
    crc16_d = {crc16_q[14:0], 1'b0} ^ ((in_bit ^ crc16_q[15]) ? CRC16_POLY : 16'd0);
  end

  // Both CRCs run in parallel; clear holds them at the all-ones seed
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc5_q  <= '1;
      crc16_q <= '1;
    end else if (clear) begin
      crc5_q  <= '1;
      crc16_q <= '1;
    end else if (enable) begin
      crc5_q  <= crc5_d;
      crc16_q <= crc16_d;
    end
  end

  // Residual comparison chosen by PID type
  always_comb begin
    case (kind)
      PID_TYPE_TOKEN:     ok = (crc5_q == CRC5_RESIDUAL);
      PID_TYPE_DATA:      ok = (crc16_q == CRC16_RESIDUAL);
      PID_TYPE_HANDSHAKE: ok = 1'b1;
      default:            ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/usb_rx_decoder.sv
// usb_rx_decoder: USB full-speed style receiver, one bit time per clock.
// Detects SYNC, NRZI-decodes, removes stuffed bits, checks EOP and
// assembles the packet body LSB-first into pkt_out.
// Optional CRC residual check is built when USB_RX_CRC_CHK_EN is defined;
// otherwise crc_ok reads 1 alongside pkt_valid.
module usb_rx_decoder
  import USBPkg::*;
#(
  parameter int MAX_BITS = 100
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                DP,
  input  logic                DM,
  output logic [MAX_BITS-1:0] pkt_out,
  output logic [31:0]         pkt_len,
  output logic                pkt_valid,
  output logic                pkt_error,
  output logic                crc_ok,
  output logic                rx_busy
);

  localparam int CW = $clog2(MAX_BITS + 1);

  rx_state_e           state_q;
  logic [1:0]          bus_q, prev_q;
  logic [13:0]         hist_q;
  logic [15:0]         hist_d;
  logic [MAX_BITS-1:0] buf_q, pkt_out_q;
  logic [CW-1:0]       count_q;
  logic [2:0]          ones_q;
  logic [31:0]         pkt_len_q;
  logic                pkt_valid_q, pkt_error_q, crc_ok_q, rx_busy_q;
  logic                is_jk, dec_bit, stuff_slot, at_cap, crc_ok_d;

  // Line decode helpers from the registered bus pair
  always_comb begin
    hist_d     = {hist_q, bus_q};
    is_jk      = (bus_q == BUS_J) || (bus_q == BUS_K);
    dec_bit    = (bus_q == prev_q);
    stuff_slot = (ones_q == 3'd6);
    at_cap     = (count_q == CW'(MAX_BITS));
  end

`ifdef USB_RX_CRC_CHK_EN
  logic crc_clear, crc_en, crc_res_ok;
  assign crc_clear = (state_q == ST_IDLE) || (state_q == ST_SYNC);
  // The PID (first 8 kept bits) is outside CRC coverage
  assign crc_en    = (state_q == ST_RECV) && is_jk && !stuff_slot && !at_cap &&
                     (count_q >= CW'(8));

  usb_rx_crc_chk u_crc_chk (
    .clock  (clock),
    .reset  (reset),
    .clear  (crc_clear),
    .enable (crc_en),
    .in_bit (dec_bit),
    .kind   (buf_q[1:0]),
    .ok     (crc_res_ok)
  );

  assign crc_ok_d = crc_res_ok && (buf_q[7:4] == ~buf_q[3:0]) && (count_q >= CW'(8));
`else
  assign crc_ok_d = 1'b1;
`endif

  // Receive FSM with registered outputs; pulses default low every cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bus_q       <= BUS_J;
      prev_q      <= BUS_J;
      hist_q      <= '0;
      buf_q       <= '0;
      count_q     <= '0;
      ones_q      <= '0;
      pkt_out_q   <= '0;
      pkt_len_q   <= '0;
      pkt_valid_q <= 1'b0;
      pkt_error_q <= 1'b0;
      crc_ok_q    <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      bus_q       <= {DP, DM};
      pkt_valid_q <= 1'b0;
      pkt_error_q <= 1'b0;
      crc_ok_q    <= 1'b0;
      case (state_q)
        ST_IDLE, ST_SYNC: begin
          hist_q <= hist_d[13:0];
          if (hist_d == SYNC_PATTERN) begin
            state_q   <= ST_RECV;
            rx_busy_q <= 1'b1;
            buf_q     <= '0;
            count_q   <= '0;
            ones_q    <= '0;
            prev_q    <= BUS_K;
            hist_q    <= '0;
          end else if (state_q == ST_SYNC) begin
            if (!is_jk) begin
              state_q   <= ST_IDLE;
              rx_busy_q <= 1'b0;
            end
          end else if (bus_q == BUS_K && hist_q[1:0] == BUS_J) begin
            state_q   <= ST_SYNC;
            rx_busy_q <= 1'b1;
          end
        end
        ST_RECV: begin
          if (is_jk) begin
            prev_q <= bus_q;
            if (stuff_slot) begin
              // Bit after six 1s must be a stuffed 0 and is dropped
              ones_q <= '0;
              if (dec_bit) begin
                state_q     <= ST_ERR;
                pkt_error_q <= 1'b1;
              end
            end else if (at_cap) begin
              state_q     <= ST_ERR;
              pkt_error_q <= 1'b1;
            end else begin
              buf_q[count_q] <= dec_bit;
              count_q        <= count_q + CW'(1);
              ones_q         <= dec_bit ? ones_q + 3'd1 : 3'd0;
            end
          end else if (bus_q == BUS_SE0) begin
            state_q <= ST_EOP1;
          end else begin
            state_q     <= ST_ERR;
            pkt_error_q <= 1'b1;
          end
        end
        ST_EOP1: begin
          if (bus_q == BUS_SE0) begin
            state_q <= ST_EOP2;
          end else begin
            state_q     <= ST_ERR;
            pkt_error_q <= 1'b1;
          end
        end
        ST_EOP2: begin
          if (bus_q == BUS_J) begin
            state_q     <= ST_DONE;
            pkt_valid_q <= 1'b1;
            pkt_len_q   <= {{(32 - CW){1'b0}}, count_q};
            pkt_out_q   <= buf_q;
            crc_ok_q    <= crc_ok_d;
          end else begin
            state_q     <= ST_ERR;
            pkt_error_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q   <= ST_IDLE;
          rx_busy_q <= 1'b0;
        end
        ST_ERR: begin
          state_q   <= ST_IDLE;
          rx_busy_q <= 1'b0;
          hist_q    <= '0;
        end
        default: begin
          state_q   <= ST_IDLE;
          rx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign pkt_out   = pkt_out_q;
  assign pkt_len   = pkt_len_q;
  assign pkt_valid = pkt_valid_q;
  assign pkt_error = pkt_error_q;
  assign crc_ok    = crc_ok_q;
  assign rx_busy   = rx_busy_q;

endmodule

// File: doc/usb_rx_decoder.md
Name: usb_rx_decoder

Overview:
Receive-side counterpart of the host transmit chain (CRC, bit-stuffer, NRZI encoder, DP/DM driver). Samples DP/DM at one bit per clock and detects SYNC. NRZI-decodes, removes stuffed bits, detects EOP, and assembles the packet body (PID onward) LSB-first into a parallel vector with a bit count. Flags bus, stuffing and overflow errors, and optionally checks the CRC residual.

Parameters:
MAX_BITS, 100, capacity of pkt_out in bits; packets longer than this are errors.

Ports:
clock  in  1  single system clock; one bit time per clock.
reset  in  1  asynchronous, active-high reset.
DP  in  1  USB D+ as seen on USBWires.
DM  in  1  USB D-.
pkt_out  out  MAX_BITS  received bits after SYNC; first bit in pkt_out[0]; unused upper bits 0.
pkt_len  out  32  number of de-stuffed bits received, excluding SYNC and EOP.
pkt_valid  out  1  one-cycle pulse: good packet; pkt_out/pkt_len are stable until the next SYNC.
pkt_error  out  1  one-cycle pulse: packet aborted.
crc_ok  out  1  CRC residual check result, qualified by pkt_valid.
rx_busy  out  1  high from the first SYNC bit until the pulse cycle, inclusive.

Behaviour:
- Bus states: J={DP,DM}=10, K=01, SE0=00, SE1=11.
- Reset values: pkt_out=0, pkt_len=0, pkt_valid=0, pkt_error=0, crc_ok=0, rx_busy=0, state=IDLE, prev_state=J.
- DP/DM are registered once. All decisions use the registered pair.
- FSM: IDLE, SYNC, RECV, EOP1, EOP2, DONE, ERR.
- IDLE: keeps an 8-deep history of bus states. On history K,J,K,J,K,J,K,K (oldest first), go to RECV, clear pkt_out and the bit counter, and set prev_state=K. SYNC is a tracking sub-state: it is entered on the first K after at least one J. Any non-J/K state while in SYNC returns to IDLE with no error.
- RECV, on J or K: decoded bit = 1 if the state equals prev_state, else 0. Then update prev_state.
- Unstuffing: a ones counter counts consecutive decoded 1s. After six 1s, the next decoded bit is discarded if it is 0, and the counter clears. If that bit is 1, go to ERR (stuff error).
- Kept bits are written to pkt_out[count], and count increments. If a kept bit arrives at count==MAX_BITS, go to ERR (overflow).
- RECV on SE0: go to EOP1. RECV on SE1: go to ERR.
- EOP1 requires SE0, then go to EOP2. EOP2 requires J, then go to DONE. Any other state in EOP1/EOP2 goes to ERR.
- An SE0 arriving while a stuffed bit is pending is legal and is not a stuff error.
- DONE lasts one cycle: pkt_valid=1, pkt_len=count, crc_ok updated. Then go to IDLE.
- ERR lasts one cycle: pkt_error=1, and pkt_len/pkt_out keep their previous good values. Then go to IDLE; the SYNC history is cleared.
- Latency: pkt_valid is high exactly 1 cycle after the registered EOP J is seen, i.e. 2 clocks after J is on the pins.
- A zero-bit packet (SYNC immediately followed by EOP) produces pkt_valid with pkt_len=0.
- Reset asserted mid-packet: all outputs return to reset values immediately, with no pulse.

Optional Feature:
USB_RX_CRC_CHK_EN
- Defined: a serial CRC runs over kept bits with all-ones init. PID type comes from pkt_out[1:0].
  - 01 (token): CRC5, polynomial x^5+x^2+1; crc_ok=1 iff final register == 5'b01100.
  - 11 (data): CRC16, polynomial x^16+x^15+x^2+1; crc_ok=1 iff final == 16'h800D.
  - 10 (handshake): crc_ok=1.
  - Also in all cases, crc_ok=0 if pkt_out[7:4] != ~pkt_out[3:0] or pkt_len<8.
- Undefined: no CRC logic is built; crc_ok=1 in the DONE cycle.

Decomposition:
- Shared package USBPkg holds:
  - bus-state encodings (J/K/SE0/SE1);
  - the SYNC pattern constant;
  - PID nibble constants;
  - CRC5/CRC16 polynomials and residuals;
  - the rx FSM enum.
- One sub-module, usb_rx_crc_chk (clear, enable, in_bit, kind, ok), instantiated only under USB_RX_CRC_CHK_EN.

Test Plan:
- Drive idle J x4, SYNC, then NRZI-encoded 19'h205E1 LSB-first, then SE0,SE0,J -> pkt_valid 1 cycle, pkt_len=19, pkt_out[18:0]=19'h205E1, pkt_error never high.
- SETUP token bytes 2D,00,10 (24 bits) with USB_RX_CRC_CHK_EN -> pkt_len=24, crc_ok=1. Flip bit 12 -> pkt_valid with crc_ok=0.
- DATA0 C3 followed by FF,00 with correct stuffing -> stuffed 0 removed, pkt_out[23:0]=24'h00FFC3. The same stream with the stuffed bit replaced by 1 -> pkt_error, no pkt_valid.
- Stream of MAX_BITS+1 kept bits -> pkt_error on bit 101. A subsequent good ACK (PID D2) -> pkt_valid, pkt_len=8.
- SE1 mid-packet, or SE0 then K at EOP -> pkt_error 1 cycle, return to IDLE, next good packet accepted.
- Assert reset at bit 10 of a packet -> all outputs 0 at once, no pulses. After deassert, a full good packet decodes normally.
